disp_source_arbiter: RTL and testbench



---
 rtl/disp_source_arbiter.sv | 149 ++++++++++++++
 tb/tb_disp_source_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/disp_source_arbiter.sv
// Picks the digit source (time / set value / message) for the 4-digit seven-segment driver.
// Define DISP_BLINK_EN to include blinking of the selected digits in set mode.
module disp_source_arbiter #(
    parameter int unsigned CLK_DIV    = 100000,
    parameter int unsigned HOLD_MS    = 2000,
    parameter int unsigned BLINK_MS   = 250,
    parameter logic [3:0]  BLANK_CODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] time_dig,
    input  logic [15:0] set_dig,
    input  logic        set_active,
    input  logic [3:0]  set_field,
    input  logic [15:0] msg_dig,
    input  logic        msg_req,
    output logic        msg_ack,
    output logic [15:0] dig_out,
    output logic [1:0]  mode
);

    localparam int unsigned      PRE_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [15:0]      HOLD_LOAD = (HOLD_MS == 0) ? 16'd1 : 16'(HOLD_MS);

    typedef enum logic [1:0] {
        ST_TIME = 2'b00,
        ST_SET  = 2'b01,
        ST_MSG  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] msg_buf_q, msg_buf_d;
    logic [15:0] dig_out_q, dig_out_d;
    logic [1:0]  mode_q, mode_d;
    logic        msg_ack_q, msg_ack_d;
    logic        ms_tick;
    logic [15:0] set_view;

    always_comb begin
        ms_tick   = (pre_q == PRE_LAST);
        pre_d     = ms_tick ? '0 : pre_q + PRE_W'(1);
        state_d   = state_q;
        hold_d    = hold_q;
        msg_buf_d = msg_buf_q;
        msg_ack_d = 1'b0;
        if (msg_req) begin
            state_d   = ST_MSG;
            msg_buf_d = msg_dig;
            msg_ack_d = 1'b1;
            hold_d    = HOLD_LOAD;
        end else begin
            case (state_q)
                ST_TIME: if (set_active) state_d = ST_SET;
                ST_SET:  if (!set_active) state_d = ST_TIME;
                ST_MSG: begin
                    if (ms_tick) begin
                        hold_d = hold_q - 16'd1;
                        if (hold_q <= 16'd1) begin
                            hold_d  = '0;
                            state_d = set_active ? ST_SET : ST_TIME;
                        end
                    end
                end
                default: state_d = ST_TIME;
            endcase
        end
    end

`ifdef DISP_BLINK_EN
    localparam logic [15:0] BLINK_LAST = (BLINK_MS == 0) ? 16'd0 : 16'(BLINK_MS - 1);

    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_ph_q, blink_ph_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        // Entry into SET restarts the phase so the first half-period is always visible.
        if (state_d == ST_SET && state_q != ST_SET) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (state_q == ST_SET && ms_tick) begin
            if (blink_cnt_q >= BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
        set_view = set_dig;
        for (int unsigned i = 0; i < 4; i++) begin
            if (set_field[i] && blink_ph_d) set_view[i*4 +: 4] = BLANK_CODE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{set_field, 16'(BLINK_MS)};

    always_comb set_view = set_dig;
`endif

    // Outputs are registered from the next-state view so they change on the causing edge.
    always_comb begin
        case (state_d)
            ST_SET:  dig_out_d = set_view;
            ST_MSG:  dig_out_d = msg_buf_d;
            default: dig_out_d = time_dig;
        endcase
        mode_d = state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_TIME;
            pre_q     <= '0;
            hold_q    <= '0;
            msg_buf_q <= '0;
            dig_out_q <= {4{BLANK_CODE}};
            mode_q    <= 2'b00;
            msg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            hold_q    <= hold_d;
            msg_buf_q <= msg_buf_d;
            dig_out_q <= dig_out_d;
            mode_q    <= mode_d;
            msg_ack_q <= msg_ack_d;
        end
    end

    assign dig_out = dig_out_q;
    assign mode    = mode_q;
    assign msg_ack = msg_ack_q;

endmodule

// File: tb/tb_disp_source_arbiter.sv
// Self-checking bench for disp_source_arbiter (CLK_DIV=4, HOLD_MS=3, BLINK_MS=2).
// Blink expectations follow DISP_BLINK_EN as defined for the build.
module tb_disp_source_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] time_dig = 16'h1234;
    logic [15:0] set_dig = 16'h0000;
    logic        set_active = 1'b0;
    logic [3:0]  set_field = 4'b0000;
    logic [15:0] msg_dig = 16'h0000;
    logic        msg_req = 1'b0;
    logic        msg_ack;
    logic [15:0] dig_out;
    logic [1:0]  mode;

    disp_source_arbiter #(
        .CLK_DIV(4),
        .HOLD_MS(3),
        .BLINK_MS(2),
        .BLANK_CODE(4'hF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .time_dig(time_dig),
        .set_dig(set_dig),
        .set_active(set_active),
        .set_field(set_field),
        .msg_dig(msg_dig),
        .msg_req(msg_req),
        .msg_ack(msg_ack),
        .dig_out(dig_out),
        .mode(mode)
    );

    always #5 clk = ~clk;

`ifdef DISP_BLINK_EN
    localparam logic [15:0] BLINKED = 16'h09FF;
`else
    localparam logic [15:0] BLINKED = 16'h0930;
`endif

    typedef struct {
        logic [15:0] dig;
        logic [1:0]  mode;
        logic        ack;
    } exp_t;

    typedef struct {
        logic [15:0] time_dig;
        logic [15:0] set_dig;
        logic        set_active;
        logic [3:0]  set_field;
        logic [15:0] exp_dig;
        logic [1:0]  exp_mode;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[18];
    int   total = 0;
    int   passed = 0;

    task automatic check_now(input string nm);
        exp_t e;
        e = sb.pop_front();
        total++;
        if (dig_out === e.dig && mode === e.mode && msg_ack === e.ack) begin
            passed++;
        end else begin
            $display("FAIL %s: got dig=%h mode=%b ack=%b, expected dig=%h mode=%b ack=%b",
                     nm, dig_out, mode, msg_ack, e.dig, e.mode, e.ack);
        end
    endtask

    task automatic expect_now(input logic [15:0] d, input logic [1:0] m, input logic a,
                              input string nm);
        sb.push_back('{dig: d, mode: m, ack: a});
        check_now(nm);
    endtask

    task automatic cyc(input logic [15:0] d, input logic [1:0] m, input logic a,
                       input string nm);
        sb.push_back('{dig: d, mode: m, ack: a});
        @(posedge clk);
        #1;
        check_now(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

    initial begin
        // Table covers edges 2..19 after reset release; ms ticks fall on edges 4, 8, 12, ...
        for (int i = 0; i < 18; i++) begin
            automatic int n = i + 2;
            vecs[i].time_dig   = (n == 19) ? 16'h4321 : 16'h0001;
            vecs[i].set_dig    = (n == 2) ? 16'h0000 : 16'h0930;
            vecs[i].set_active = (n >= 3 && n <= 17);
            vecs[i].set_field  = (n == 2) ? 4'b0000 : 4'b0011;
            if (n >= 3 && n <= 17) begin
                vecs[i].exp_mode = 2'b01;
                vecs[i].exp_dig  = (n >= 8 && n <= 15) ? BLINKED : 16'h0930;
            end else begin
                vecs[i].exp_mode = 2'b00;
                vecs[i].exp_dig  = vecs[i].time_dig;
            end
        end

        // Asynchronous reset, asserted between clock edges.
        #2 rst = 1'b1;
        #1 expect_now(16'hFFFF, 2'b00, 1'b0, "rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(16'h1234, 2'b00, 1'b0, "rst_release");

        for (int i = 0; i < 18; i++) begin
            time_dig   = vecs[i].time_dig;
            set_dig    = vecs[i].set_dig;
            set_active = vecs[i].set_active;
            set_field  = vecs[i].set_field;
            cyc(vecs[i].exp_dig, vecs[i].exp_mode, 1'b0, $sformatf("vec%0d", i + 2));
        end

        // Message hold from TIME: accepted on edge 20, expires on the third tick (edge 32).
        msg_req = 1'b1;
        msg_dig = 16'hABCD;
        cyc(16'hABCD, 2'b10, 1'b1, "msg_accept");
        msg_req = 1'b0;
        msg_dig = 16'h0000;
        for (int k = 0; k < 11; k++) cyc(16'hABCD, 2'b10, 1'b0, $sformatf("msg_hold%0d", k));
        cyc(16'h4321, 2'b00, 1'b0, "msg_expire");

        // Message request wins over a same-cycle set request; expiry then lands in SET.
        msg_req    = 1'b1;
        msg_dig    = 16'hBEEF;
        set_active = 1'b1;
        cyc(16'hBEEF, 2'b10, 1'b1, "prio_accept");
        msg_req = 1'b0;
        for (int k = 0; k < 10; k++) cyc(16'hBEEF, 2'b10, 1'b0, $sformatf("prio_hold%0d", k));
        cyc(16'h0930, 2'b01, 1'b0, "prio_to_set");
        cyc(16'h0930, 2'b01, 1'b0, "prio_set_visible");

        // Retrigger inside MSG restarts the hold.
        msg_req = 1'b1;
        msg_dig = 16'h1111;
        cyc(16'h1111, 2'b10, 1'b1, "retrig_first");
        msg_req = 1'b0;
        for (int k = 0; k < 3; k++) cyc(16'h1111, 2'b10, 1'b0, $sformatf("retrig_pre%0d", k));
        msg_req    = 1'b1;
        msg_dig    = 16'h5555;
        set_active = 1'b0;
        cyc(16'h5555, 2'b10, 1'b1, "retrig_ack");
        msg_req = 1'b0;
        msg_dig = 16'h0000;
        for (int k = 0; k < 9; k++) cyc(16'h5555, 2'b10, 1'b0, $sformatf("retrig_hold%0d", k));
        cyc(16'h4321, 2'b00, 1'b0, "retrig_expire");

        // Asynchronous reset in the middle of a message.
        msg_req = 1'b1;
        msg_dig = 16'h7777;
        cyc(16'h7777, 2'b10, 1'b1, "rmsg_accept");
        msg_req = 1'b0;
        cyc(16'h7777, 2'b10, 1'b0, "rmsg_hold");
        #2 rst = 1'b1;
        #1 expect_now(16'hFFFF, 2'b00, 1'b0, "rst_in_msg");
        set_active = 1'b1;
        set_dig    = 16'h2468;
        cyc(16'hFFFF, 2'b00, 1'b0, "rst_held");
        #3 rst = 1'b0;
        #1 expect_now(16'hFFFF, 2'b00, 1'b0, "rst_off_time");
        cyc(16'h2468, 2'b01, 1'b0, "set_after_rst");
        cyc(16'h2468, 2'b01, 1'b0, "set_no_ack");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
